// File: rtl/lsu_dbus_pkg.sv
// Shared dbus types used between the core-side initiators and the interconnect.
package lsu_dbus_pkg;

  parameter int unsigned XLEN = 32;

  // Initiator-to-interconnect request bundle.
  typedef struct packed {
    logic            req;
    logic            wr;
    logic [3:0]      mask;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data_wr;
  } type_core2dbus_s;

  // Responder-to-initiator completion bundle.
  typedef struct packed {
    logic            ack;
    logic [XLEN-1:0] data_rd;
  } type_dbus2core_s;

endpackage

// File: rtl/lsu_dbus_initiator.sv
// Load/store initiator on the dbus: one transaction at a time. It generates the byte
// mask and lane-replicated store data, rejects misaligned requests without touching
// the bus, extends load data and aborts a transaction left without ack for too long.
module lsu_dbus_initiator
  import lsu_dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem2lsu_req_i,
  input  logic            mem2lsu_wr_i,
  input  logic [1:0]      mem2lsu_size_i,
  input  logic            mem2lsu_unsigned_i,
  input  logic [XLEN-1:0] mem2lsu_addr_i,
  input  logic [XLEN-1:0] mem2lsu_wdata_i,
  output logic            lsu2mem_ready_o,
  output logic            lsu2mem_done_o,
  output logic [XLEN-1:0] lsu2mem_rdata_o,
  output logic            lsu2mem_misalign_o,
  output logic            lsu2mem_timeout_o,
  output type_core2dbus_s lsu2dbus_o,
  input  type_dbus2core_s dbus2lsu_i
);

  typedef enum logic [1:0] {StIdle, StBusy, StReport} state_e;

  // Counter value in the last BUSY cycle before the abort.
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  type_core2dbus_s bus_q, bus_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            mis_q, mis_d;
  logic            to_q, to_d;

  logic            req_misalign;
  logic [3:0]      req_mask;
  logic [XLEN-1:0] req_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  // Decode the incoming request: alignment check, byte mask and replicated store data.
  always_comb begin
    req_misalign = 1'b0;
    req_mask     = 4'b1111;
    req_wdata    = mem2lsu_wdata_i;
    case (mem2lsu_size_i)
      2'b00: begin
        req_mask  = 4'b0001 << mem2lsu_addr_i[1:0];
        req_wdata = {4{mem2lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        req_misalign = mem2lsu_addr_i[0];
        req_mask     = 4'b0011 << {mem2lsu_addr_i[1], 1'b0};
        req_wdata    = {2{mem2lsu_wdata_i[15:0]}};
      end
      2'b10: begin
        req_misalign = |mem2lsu_addr_i[1:0];
      end
      default: begin
        req_misalign = 1'b1;
      end
    endcase
  end

  // Pick the addressed lane out of the read data and extend it to XLEN.
  always_comb begin
    case (bus_q.addr[1:0])
      2'b00:   ld_byte = dbus2lsu_i.data_rd[7:0];
      2'b01:   ld_byte = dbus2lsu_i.data_rd[15:8];
      2'b10:   ld_byte = dbus2lsu_i.data_rd[23:16];
      default: ld_byte = dbus2lsu_i.data_rd[31:24];
    endcase
    ld_half = bus_q.addr[1] ? dbus2lsu_i.data_rd[31:16] : dbus2lsu_i.data_rd[15:0];
    case (size_q)
      2'b00:   ld_data = {{(XLEN - 8){~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN - 16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = dbus2lsu_i.data_rd;
    endcase
  end

  // Next-state logic for the transaction FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    size_d  = size_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem2lsu_req_i) begin
          if (req_misalign) begin
            mis_d   = 1'b1;
            state_d = StReport;
          end else begin
            bus_d.req     = 1'b1;
            bus_d.wr      = mem2lsu_wr_i;
            bus_d.mask    = req_mask;
            bus_d.addr    = mem2lsu_addr_i;
            bus_d.data_wr = mem2lsu_wr_i ? req_wdata : '0;
            size_d        = mem2lsu_size_i;
            uns_d         = mem2lsu_unsigned_i;
            cnt_d         = '0;
            state_d       = StBusy;
          end
        end
      end
      StBusy: begin
        // ack takes priority over an expiring counter in the same cycle
        if (dbus2lsu_i.ack) begin
          bus_d.req = 1'b0;
          done_d    = 1'b1;
          if (!bus_q.wr) rdata_d = ld_data;
          state_d   = StReport;
        end else if (cnt_q == CntLast) begin
          bus_d.req = 1'b0;
          to_d      = 1'b1;
          state_d   = StReport;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bus_q   <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
    end
  end

  assign lsu2mem_ready_o    = (state_q == StIdle);
  assign lsu2mem_done_o     = done_q;
  assign lsu2mem_rdata_o    = rdata_q;
  assign lsu2mem_misalign_o = mis_q;
  assign lsu2mem_timeout_o  = to_q;
  assign lsu2dbus_o         = bus_q;

endmodule

// File: tb/tb_lsu_dbus_initiator.sv
// Directed bench for lsu_dbus_initiator with a hand-driven responder.
module tb_lsu_dbus_initiator;
  import lsu_dbus_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            req;
  logic            wr;
  logic [1:0]      size;
  logic            uns;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            ready;
  logic            done;
  logic [31:0]     rdata;
  logic            misalign;
  logic            timeout;
  type_core2dbus_s bus;
  type_dbus2core_s resp;

  int n_cmp = 0;
  int n_err = 0;

  lsu_dbus_initiator #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem2lsu_req_i     (req),
    .mem2lsu_wr_i      (wr),
    .mem2lsu_size_i    (size),
    .mem2lsu_unsigned_i(uns),
    .mem2lsu_addr_i    (addr),
    .mem2lsu_wdata_i   (wdata),
    .lsu2mem_ready_o   (ready),
    .lsu2mem_done_o    (done),
    .lsu2mem_rdata_o   (rdata),
    .lsu2mem_misalign_o(misalign),
    .lsu2mem_timeout_o (timeout),
    .lsu2dbus_o        (bus),
    .dbus2lsu_i        (resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one accept edge; returns in the first cycle after it.
  task automatic start(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    check_eq("ready_before_req", 32'(ready), 32'd1);
    wr = w; size = s; uns = u; addr = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // Full transaction acked in the first BUSY cycle.
  task automatic txn_ack(input string tag, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                         input logic [3:0] exp_mask, input logic [31:0] exp_dwr,
                         input logic [31:0] exp_rdata);
    start(w, s, u, a, d);
    check_eq({tag, "_req"}, 32'(bus.req), 32'd1);
    check_eq({tag, "_wr"}, 32'(bus.wr), 32'(w));
    check_eq({tag, "_mask"}, 32'(bus.mask), 32'(exp_mask));
    check_eq({tag, "_addr"}, bus.addr, a);
    check_eq({tag, "_data_wr"}, bus.data_wr, exp_dwr);
    check_eq({tag, "_busy_ready"}, 32'(ready), 32'd0);
    resp.ack = 1'b1; resp.data_rd = rd;
    tick();
    resp.ack = 1'b0; resp.data_rd = 32'h0;
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_req_off"}, 32'(bus.req), 32'd0);
    check_eq({tag, "_report_ready"}, 32'(ready), 32'd0);
    tick();
    check_eq({tag, "_ready_back"}, 32'(ready), 32'd1);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // Misaligned/illegal request: pulse next cycle, bus never requested.
  task automatic txn_mis(input string tag, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] exp_rdata);
    start(1'b0, s, 1'b0, a, 32'h0);
    check_eq({tag, "_misalign"}, 32'(misalign), 32'd1);
    check_eq({tag, "_req"}, 32'(bus.req), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_ready"}, 32'(ready), 32'd0);
    tick();
    check_eq({tag, "_ready_back"}, 32'(ready), 32'd1);
    check_eq({tag, "_mis_pulse"}, 32'(misalign), 32'd0);
    check_eq({tag, "_req_after"}, 32'(bus.req), 32'd0);
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; resp = '0;
    tick(); tick();
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_bus_ctl", {26'h0, bus.req, bus.wr, bus.mask}, 32'h0);
    check_eq("rst_bus_addr", bus.addr, 32'h0);
    check_eq("rst_bus_dwr", bus.data_wr, 32'h0);
    rst_n = 1'b1;
    tick();

    txn_ack("ldw", 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
            4'b1111, 32'h0, 32'hDEAD_BEEF);
    txn_ack("ldb_s", 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000,
            4'b1000, 32'h0, 32'hFFFF_FF80);
    txn_ack("ldb_u", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000,
            4'b1000, 32'h0, 32'h0000_0080);
    txn_ack("sth", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'h5555_5555,
            4'b1100, 32'hABCD_ABCD, 32'h0000_0080);
    txn_ack("stb", 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00AB, 32'h5555_5555,
            4'b0010, 32'hABAB_ABAB, 32'h0000_0080);
    txn_ack("ldh_s", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7777,
            4'b1100, 32'h0, 32'hFFFF_8001);

    txn_mis("mis_w", 2'b10, 32'h0000_0101, 32'hFFFF_8001);
    txn_mis("mis_sz", 2'b11, 32'h0000_0100, 32'hFFFF_8001);
    txn_mis("mis_h", 2'b01, 32'h0000_0103, 32'hFFFF_8001);

    // No ack: req must stay up exactly TIMEOUT_CYCLES cycles.
    start(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.req) break;
      cyc++;
      tick();
    end
    check_eq("to_req_cycles", 32'(cyc), 32'd4);
    check_eq("to_timeout", 32'(timeout), 32'd1);
    check_eq("to_done", 32'(done), 32'd0);
    check_eq("to_rdata", rdata, 32'hFFFF_8001);
    tick();
    check_eq("to_ready_back", 32'(ready), 32'd1);
    check_eq("to_pulse", 32'(timeout), 32'd0);

    // ack in the last allowed cycle completes normally.
    start(1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0);
    tick(); tick(); tick();
    check_eq("late_req_4th", 32'(bus.req), 32'd1);
    resp.ack = 1'b1; resp.data_rd = 32'h0000_1234;
    tick();
    resp.ack = 1'b0; resp.data_rd = 32'h0;
    check_eq("late_done", 32'(done), 32'd1);
    check_eq("late_timeout", 32'(timeout), 32'd0);
    check_eq("late_rdata", rdata, 32'h0000_1234);
    tick();
    check_eq("late_ready", 32'(ready), 32'd1);
    check_eq("late_to_after", 32'(timeout), 32'd0);

    // Stray ack while idle must be ignored.
    resp.ack = 1'b1; resp.data_rd = 32'hFFFF_FFFF;
    tick();
    resp.ack = 1'b0; resp.data_rd = 32'h0;
    check_eq("idle_ack_done", 32'(done), 32'd0);
    check_eq("idle_ack_rdata", rdata, 32'h0000_1234);

    // Asynchronous reset in the middle of BUSY.
    start(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    check_eq("rstmid_req_before", 32'(bus.req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_req", 32'(bus.req), 32'd0);
    check_eq("rstmid_ready", 32'(ready), 32'd1);
    check_eq("rstmid_rdata", rdata, 32'h0);
    check_eq("rstmid_addr", bus.addr, 32'h0);
    check_eq("rstmid_flags", {29'h0, done, misalign, timeout}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rstmid_no_pulse", {29'h0, done, misalign, timeout}, 32'h0);
    txn_ack("post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D,
            4'b1111, 32'h0, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
